// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output FIFO.
// Strips the header, streams payload, checks parity/address, aborts on starvation.
module router_dest_reader #(
  parameter logic [1:0] MY_ADDR     = 2'b00,
  parameter int         TIMEOUT_CYC = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_in,
  input  logic       dest_ready,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_first,
  output logic       byte_last,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       timeout_err,
  output logic       fifo_soft_reset,
  output logic       busy
);

  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    addr_q;
  logic [6:0]    req_left;
  logic [6:0]    rcv_left;
  logic [7:0]    par;
  logic          rd_pending;
  logic          first_pend;
  logic [SW-1:0] starve_cnt;

  logic in_body;
  logic req_nz;
  logic starving;
  logic time_up;
  logic take;
  logic is_payload;
  logic is_parity;
  logic addr_ok;

  assign in_body    = (state == S_BODY);
  assign req_nz     = (req_left != 7'd0);
  assign starving   = in_body & req_nz & ~vld_out;
  assign time_up    = in_body & (starve_cnt == SW'(TIMEOUT_CYC));
  assign take       = in_body & rd_pending & ~time_up;
  assign is_payload = take & (rcv_left > 7'd1);
  assign is_parity  = take & (rcv_left == 7'd1);
  assign addr_ok    = (addr_q == MY_ADDR);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (vld_out & dest_ready) state_nxt = S_HDR;
      S_HDR:  state_nxt = S_BODY;
      S_BODY: begin
        if (time_up)        state_nxt = S_IDLE;
        else if (is_parity) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: read strobe, byte stream, status pulses
  always_comb begin
    read_enb = 1'b0;
    pkt_done = 1'b0;
    busy     = 1'b0;
    unique case (state)
      S_IDLE: read_enb = vld_out & dest_ready;
      S_HDR:  busy = 1'b1;
      S_BODY: begin
        busy     = 1'b1;
        read_enb = vld_out & dest_ready & req_nz & ~time_up;
      end
      S_DONE: pkt_done = 1'b1;
      default: ;
    endcase
    read_enb        = read_enb & resetn;
    byte_valid      = is_payload & addr_ok;
    byte_data       = byte_valid ? data_in : 8'h00;
    byte_first      = byte_valid & first_pend;
    byte_last       = byte_valid & (rcv_left == 7'd2);
    timeout_err     = time_up;
    fifo_soft_reset = time_up;
  end

  // Packet datapath: counters, parity accumulator, error flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= 2'b00;
      req_left   <= 7'd0;
      rcv_left   <= 7'd0;
      par        <= 8'h00;
      rd_pending <= 1'b0;
      first_pend <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        S_HDR: begin
          addr_q     <= data_in[1:0];
          par        <= data_in;
          req_left   <= {1'b0, data_in[7:2]} + 7'd1;
          rcv_left   <= {1'b0, data_in[7:2]} + 7'd1;
          parity_err <= 1'b0;
          addr_err   <= 1'b0;
          first_pend <= 1'b1;
          rd_pending <= 1'b0;
          starve_cnt <= '0;
        end
        S_BODY: begin
          rd_pending <= read_enb;
          if (read_enb) req_left <= req_left - 7'd1;
          if (take)     rcv_left <= rcv_left - 7'd1;
          if (is_payload) begin
            par        <= par ^ data_in;
            first_pend <= 1'b0;
          end
          if (is_parity) begin
            parity_err <= (par != data_in);
            addr_err   <= ~addr_ok;
          end
          if (time_up | vld_out) starve_cnt <= '0;
          else if (starving)     starve_cnt <= starve_cnt + 1'b1;
        end
        default: begin
          rd_pending <= 1'b0;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: FIFO model, packet-level reference,
// table vectors, randomized traffic and directed corner sequences.
module tb_router_dest_reader;

  localparam logic [1:0] MY = 2'b00;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         len;
    logic [1:0] addr;
    bit         bad;
    bit         exp_perr;
    bit         exp_aerr;
    int         exp_n;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out;
  logic [7:0] data_in = 8'h00;
  logic       dest_ready;
  logic       read_enb, byte_valid, byte_first, byte_last, pkt_done;
  logic [7:0] byte_data;
  logic       parity_err, addr_err, timeout_err, fifo_soft_reset, busy;

  router_dest_reader #(.MY_ADDR(MY), .TIMEOUT_CYC(30)) dut (
    .clock(clock), .resetn(resetn), .vld_out(vld_out),
    .data_in(data_in), .dest_ready(dest_ready),
    .read_enb(read_enb), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_first(byte_first),
    .byte_last(byte_last), .pkt_done(pkt_done),
    .parity_err(parity_err), .addr_err(addr_err),
    .timeout_err(timeout_err), .fifo_soft_reset(fifo_soft_reset),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // FIFO model feeding the reader
  logic [7:0] mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  flush_req = 0;
  bit  rnd_mode = 0;
  bit  rnd_dr = 1, rnd_hold = 0;
  bit  dr_man = 1, hold_man = 0;

  assign dest_ready = rnd_mode ? rnd_dr : dr_man;
  assign vld_out = (wr_ptr != rd_ptr) && !(rnd_mode ? rnd_hold : hold_man);

  always @(posedge clock) begin
    if (fifo_soft_reset || flush_req) rd_ptr <= wr_ptr;
    else if (read_enb) begin
      data_in <= mem[rd_ptr % 4096];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always begin
    @(posedge clock);
    #1;
    rnd_dr   = ($urandom % 4) != 0;
    rnd_hold = ($urandom % 6) == 0;
  end

  // Output monitor
  int cyc = 0, rd_cnt = 0, last_rd_cyc = 0, done_cyc = 0;
  int to_cnt = 0, to_cyc = 0, sr_cnt = 0;
  logic [9:0] bq[$];
  logic [1:0] dq[$];

  always @(negedge clock) begin
    cyc++;
    if (resetn) begin
      if (read_enb) begin rd_cnt++; last_rd_cyc = cyc; end
      if (byte_valid) bq.push_back({byte_data, byte_first, byte_last});
      if (pkt_done) begin dq.push_back({parity_err, addr_err}); done_cyc = cyc; end
      if (timeout_err) begin to_cnt++; to_cyc = cyc; end
      if (fifo_soft_reset) sr_cnt++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bq_t mk_pkt(int len, logic [1:0] addr, bit bad, bit rnd);
    bq_t q;
    logic [7:0] x, b;
    q.push_back({len[5:0], addr});
    x = q[0];
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
      q.push_back(b);
      x ^= b;
    end
    q.push_back(bad ? (x ^ 8'h01) : x);
    return q;
  endfunction

  task automatic push(input bq_t q, int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 4096] = q[i];
      wr_ptr++;
    end
  endtask

  task automatic wait_done(int d0, int budget);
    for (int i = 0; i < budget && dq.size() == d0; i++) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Reference: expected stream and status derived from packet bytes alone
  task automatic check_pkt(input bq_t pkt, int b0, int d0, int r0, int t0, string tag);
    int len, n;
    logic [1:0] a;
    logic [7:0] x;
    bit perr, aerr;
    logic [9:0] e;
    len = int'(pkt[0][7:2]);
    a = pkt[0][1:0];
    x = 8'h00;
    for (int i = 0; i <= len; i++) x ^= pkt[i];
    perr = (x != pkt[len + 1]);
    aerr = (a != MY);
    n = aerr ? 0 : len;
    chk({tag, "_done"}, 32'(dq.size() - d0), 32'd1);
    chk({tag, "_nbytes"}, 32'(bq.size() - b0), 32'(n));
    for (int i = 0; i < n && b0 + i < bq.size(); i++) begin
      e = {pkt[i + 1], 1'(i == 0), 1'(i == len - 1)};
      chk({tag, "_byte"}, 32'(bq[b0 + i]), 32'(e));
    end
    if (dq.size() > d0) begin
      chk({tag, "_perr"}, 32'(dq[d0][1]), 32'(perr));
      chk({tag, "_aerr"}, 32'(dq[d0][0]), 32'(aerr));
    end
    chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'(len + 2));
    chk({tag, "_lat"}, 32'(done_cyc - last_rd_cyc), 32'd2);
    chk({tag, "_drained"}, 32'(wr_ptr - rd_ptr), 32'd0);
    chk({tag, "_to"}, 32'(to_cnt - t0), 32'd0);
  endtask

  task automatic run_pkt(input bq_t pkt, string tag);
    int b0, d0, r0, t0;
    b0 = bq.size(); d0 = dq.size(); r0 = rd_cnt; t0 = to_cnt;
    @(posedge clock);
    #1;
    push(pkt, pkt.size());
    wait_done(d0, 600);
    check_pkt(pkt, b0, d0, r0, t0, tag);
  endtask

  task automatic chk_outs_zero(string tag);
    chk(tag, 32'({read_enb, byte_valid, byte_data, byte_first, byte_last,
                  pkt_done, parity_err, addr_err, timeout_err,
                  fifo_soft_reset, busy}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  vec_t vt[8];
  bq_t  pkt;

  initial begin
    int b0, d0, r0, t0, s0, dwin;
    vt[0] = '{3, 2'd0, 0, 0, 0, 3};
    vt[1] = '{3, 2'd0, 1, 1, 0, 3};
    vt[2] = '{1, 2'd1, 0, 0, 1, 0};
    vt[3] = '{0, 2'd0, 0, 0, 0, 0};
    vt[4] = '{1, 2'd0, 0, 0, 0, 1};
    vt[5] = '{63, 2'd0, 0, 0, 0, 63};
    vt[6] = '{5, 2'd2, 1, 1, 1, 0};
    vt[7] = '{2, 2'd3, 0, 0, 1, 0};

    repeat (3) @(posedge clock);
    #1;
    chk_outs_zero("reset_outs");
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk_outs_zero("idle_outs");

    for (int k = 0; k < 8; k++) begin
      b0 = bq.size(); d0 = dq.size();
      pkt = mk_pkt(vt[k].len, vt[k].addr, vt[k].bad, 0);
      run_pkt(pkt, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_tbl_n", k), 32'(bq.size() - b0), 32'(vt[k].exp_n));
      if (dq.size() > d0) begin
        chk($sformatf("vec%0d_tbl_perr", k), 32'(dq[d0][1]), 32'(vt[k].exp_perr));
        chk($sformatf("vec%0d_tbl_aerr", k), 32'(dq[d0][0]), 32'(vt[k].exp_aerr));
      end
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_err_hold", k), 32'({parity_err, addr_err}),
          32'({vt[k].exp_perr, vt[k].exp_aerr}));
    end

    // dest_ready stall mid-payload
    pkt = mk_pkt(6, MY, 0, 1);
    b0 = bq.size(); d0 = dq.size(); r0 = rd_cnt; t0 = to_cnt;
    @(posedge clock);
    #1;
    push(pkt, pkt.size());
    for (int i = 0; i < 50 && bq.size() - b0 < 2; i++) begin
      @(negedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    dr_man = 0;
    repeat (5) begin
      @(negedge clock);
      #1;
      chk("stall_rd", 32'(read_enb), 32'd0);
    end
    @(posedge clock);
    #1;
    dr_man = 1;
    wait_done(d0, 100);
    check_pkt(pkt, b0, d0, r0, t0, "stall");

    // starvation after two of three payload bytes
    pkt = mk_pkt(3, MY, 0, 0);
    b0 = bq.size(); d0 = dq.size(); t0 = to_cnt; s0 = sr_cnt;
    @(posedge clock);
    #1;
    push(pkt, 3);
    for (int i = 0; i < 80 && to_cnt == t0; i++) begin
      @(negedge clock);
      #1;
    end
    repeat (5) @(negedge clock);
    #1;
    dwin = to_cyc - last_rd_cyc;
    chk("to_pulses", 32'(to_cnt - t0), 32'd1);
    chk("to_softrst", 32'(sr_cnt - s0), 32'd1);
    chk("to_nodone", 32'(dq.size() - d0), 32'd0);
    chk("to_window", 32'(dwin >= 30 && dwin <= 32), 32'd1);
    chk("to_nbytes", 32'(bq.size() - b0), 32'd2);
    if (bq.size() - b0 >= 2) begin
      chk("to_b0", 32'(bq[b0]), 32'({8'h11, 2'b10}));
      chk("to_b1", 32'(bq[b0 + 1]), 32'({8'h22, 2'b00}));
    end
    chk("to_idle", 32'(busy), 32'd0);
    run_pkt(mk_pkt(3, MY, 0, 0), "after_to");

    // randomized traffic with backpressure and FIFO gaps
    rnd_mode = 1;
    for (int k = 0; k < 25; k++) begin
      logic [1:0] a;
      a = (($urandom % 3) == 0) ? 2'($urandom) : MY;
      pkt = mk_pkt($urandom_range(0, 12), a, ($urandom % 4) == 0, 1);
      run_pkt(pkt, $sformatf("rnd%0d", k));
    end
    rnd_mode = 0;

    // asynchronous reset mid-body
    pkt = mk_pkt(8, MY, 0, 1);
    b0 = bq.size();
    @(posedge clock);
    #1;
    push(pkt, pkt.size());
    for (int i = 0; i < 50 && bq.size() - b0 < 2; i++) begin
      @(negedge clock);
      #1;
    end
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk_outs_zero("rst_mid_outs");
    flush_req = 1;
    @(posedge clock);
    #1;
    flush_req = 0;
    chk_outs_zero("rst_hold_outs");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    d0 = dq.size();
    run_pkt(mk_pkt(0, MY, 0, 0), "post_rst");
    chk("post_rst_single", 32'(dq.size() - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
